// File: rtl/apple_placer_if.sv
// Request/result and board-state bundle between the snake game and apple_placer.
// The game side is the master (request, board view); the placer is the slave.
interface apple_placer_if #(
    parameter int MAX_LENGTH = 30,
    parameter int NUM_WALLS  = 25
);
    logic                      good_collision;
    logic [7:0]                apple_possible;
    logic [3:0]                snake_head_x;
    logic [3:0]                snake_head_y;
    logic [4:0]                snake_length;
    logic [MAX_LENGTH*4-1:0]   snakeArrayX;
    logic [MAX_LENGTH*4-1:0]   snakeArrayY;
    logic [NUM_WALLS*8-1:0]    wall_locations;
    logic [3:0]                XMAX;
    logic [3:0]                XMIN;
    logic [3:0]                YMAX;
    logic [3:0]                YMIN;
    logic [7:0]                other_apple;
    logic                      enable;
    logic [7:0]                apple_location;
    logic                      busy;
    logic                      done;
    logic                      fail;

    modport master (
        output good_collision, apple_possible, snake_head_x, snake_head_y, snake_length,
               snakeArrayX, snakeArrayY, wall_locations, XMAX, XMIN, YMAX, YMIN, other_apple,
        input  enable, apple_location, busy, done, fail
    );

    modport slave (
        input  good_collision, apple_possible, snake_head_x, snake_head_y, snake_length,
               snakeArrayX, snakeArrayY, wall_locations, XMAX, XMIN, YMAX, YMIN, other_apple,
        output enable, apple_location, busy, done, fail
    );
endinterface

// File: rtl/apple_placer.sv
// Rolls random {y,x} apple candidates, scanning one body/wall entry per cycle: 3+MAX_LENGTH(+NUM_WALLS) cycles per clean try.
// Requests are ignored while busy; the wall scan is compiled only with APPLE_PLACER_WALL_CHECK_EN.
module apple_placer #(
    parameter int MAX_LENGTH = 30,
    parameter int MAX_TRIES  = 16,
    parameter int NUM_WALLS  = 25
) (
    input  logic          system_clk,
    input  logic          reset,
    apple_placer_if.slave bus
);
    localparam int IDX_N = (MAX_LENGTH > NUM_WALLS) ? MAX_LENGTH : NUM_WALLS;
    localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [IDX_W-1:0] LAST_SEG  = IDX_W'(MAX_LENGTH - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_BOUNDS,
        S_BODY,
`ifdef APPLE_PLACER_WALL_CHECK_EN
        S_WALL,
`endif
        S_REROLL,
        S_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [7:0]       loc_q, loc_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             reject;
    logic [4:0]       len_eff;
    logic             seg_live;
    logic             seg_hit;
    logic             out_of_area;

    // Oversized lengths clamp so the scan never reads past the body array.
    assign len_eff  = (32'(bus.snake_length) > MAX_LENGTH) ? 5'(MAX_LENGTH) : bus.snake_length;
    assign seg_live = 32'(idx_q) < 32'(len_eff);
    assign seg_hit  = seg_live &&
                      (cand_q == {bus.snakeArrayY[{idx_q, 2'b00} +: 4],
                                  bus.snakeArrayX[{idx_q, 2'b00} +: 4]});

    assign out_of_area = (cand_q[3:0] < bus.XMIN) || (cand_q[3:0] > bus.XMAX) ||
                         (cand_q[7:4] < bus.YMIN) || (cand_q[7:4] > bus.YMAX);

`ifdef APPLE_PLACER_WALL_CHECK_EN
    localparam logic [IDX_W-1:0] LAST_WALL = IDX_W'(NUM_WALLS - 1);
    logic wall_hit;
    assign wall_hit = (cand_q == bus.wall_locations[{idx_q, 3'b000} +: 8]);
`else
    logic unused_walls;
    assign unused_walls = ^bus.wall_locations;
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        loc_d   = loc_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        reject  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.good_collision) begin
                    state_d = S_SAMPLE;
                    tries_d = '0;
                end
            end
            S_SAMPLE: begin
                cand_d  = bus.apple_possible;
                state_d = S_BOUNDS;
            end
            S_BOUNDS: begin
                if (out_of_area ||
                    (cand_q == {bus.snake_head_y, bus.snake_head_x}) ||
                    (cand_q == bus.other_apple)) begin
                    reject = 1'b1;
                end else begin
                    idx_d   = '0;
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (seg_hit) begin
                    reject = 1'b1;
                end else if (idx_q == LAST_SEG) begin
                    idx_d   = '0;
`ifdef APPLE_PLACER_WALL_CHECK_EN
                    state_d = S_WALL;
`else
                    state_d = S_COMMIT;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`ifdef APPLE_PLACER_WALL_CHECK_EN
            S_WALL: begin
                if (wall_hit) begin
                    reject = 1'b1;
                end else if (idx_q == LAST_WALL) begin
                    idx_d   = '0;
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`endif
            S_REROLL: begin
                state_d = S_SAMPLE;
            end
            S_COMMIT: begin
                loc_d   = cand_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared reject path: count the try, then give up or ask for a fresh number.
        if (reject) begin
            tries_d = tries_q + TRY_W'(1);
            if (tries_d == TRY_LIMIT) begin
                fail_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_REROLL;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            loc_q   <= 8'h55;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            loc_q   <= loc_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.enable         = (state_q == S_REROLL);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_q;
    assign bus.fail           = fail_q;
    assign bus.apple_location = loc_q;
endmodule
